gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctl: RTL
========================================

GF180MCU_FD_SC_MCU7T5V0__CLKDIV_CTL -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, named CLK and RN.
REQ-002 Ports SHALL be as follows, one per line, in the order name, direction, width, meaning.
- CLK  input  1  Source clock; all state updates on its rising edge.
- RN  input  1  Asynchronous active-low reset.
- EN  input  1  Run request for the divided clock.
- DIV  input  4  Half-period length minus 1, in CLK cycles.
- LOAD  input  1  One-cycle strobe that captures DIV as a pending ratio.
- Z  output  1  Registered divided clock; feeds the downstream clkinv tree.
- RUN  output  1  High whenever the FSM is not in IDLE.
- PEND  output  1  A captured ratio is waiting for a safe boundary.
- ACK  output  1  One-cycle pulse when a pending ratio becomes active.
- VDD  inout  1  Power pin; no functional effect.
- VSS  inout  1  Ground pin; no functional effect.
REQ-003 There SHALL be no parameters; the width of DIV is fixed at 4.

Function
REQ-004 Internal state SHALL be as follows.
- FSM with three states: IDLE, HIGH, LOW.
- 4-bit phase counter CNT.
- 4-bit active ratio register ACT.
- 4-bit pending register PDV.
- PEND flag.
REQ-005 Z SHALL be driven directly from a flop, with no combinational path from any input to Z.
REQ-006 Z SHALL be 1 in HIGH and 0 in IDLE and LOW, so Z is glitch-free by construction.
REQ-007 IDLE behaviour:
- CNT is held at 0.
- If EN=1 at an edge, the next state is HIGH with CNT=0, so Z=1 after that edge (latency 1 cycle).
REQ-008 HIGH behaviour:
- CNT increments each edge.
- When CNT==ACT at an edge, the next state is LOW with CNT=0.
- The high phase therefore lasts ACT+1 cycles.
REQ-009 LOW behaviour:
- CNT increments each edge.
- When CNT==ACT at an edge, the next state is HIGH if EN=1, otherwise IDLE; CNT becomes 0 in both cases.
REQ-010 The output period SHALL be 2*(ACT+1) CLK cycles with exactly 50% duty, covering ratios 2..32.
REQ-011 Deassertion of EN SHALL never truncate a phase.
- EN=0 during HIGH or LOW completes the current full period.
- Z stops low, entering IDLE at the end of LOW.
REQ-012 LOAD=1 at an edge SHALL set PDV=DIV and PEND=1.
REQ-013 A LOAD while PEND=1 SHALL overwrite PDV (last value wins) and SHALL NOT generate an extra ACK.
REQ-014 Apply boundary: the edge leaving LOW (CNT==ACT), or any edge in IDLE.
REQ-015 At an apply boundary with PEND=1 before the edge, the block SHALL perform all of the following:
- set ACT=PDV;
- clear PEND;
- pulse ACK=1 for exactly the following cycle.
REQ-016 A LOAD on the same edge as an apply boundary SHALL apply any previously pending value, and the new DIV SHALL become pending for the next boundary.
- In that case PEND stays 1.
- ACK still pulses for the applied value.
REQ-017 A ratio change SHALL never take effect mid-period.
- HIGH and LOW phases within one period always use the same ACT.
REQ-018 RUN SHALL equal (state != IDLE), driven from a flop.
REQ-019 DIV SHALL be ignored except on edges where LOAD=1.

Reset
REQ-020 RN=0 SHALL immediately and asynchronously force the following values:
- state=IDLE;
- Z=0;
- RUN=0;
- CNT=0;
- ACT=0 (divide-by-2);
- PDV=0;
- PEND=0;
- ACK=0.
REQ-021 Reset asserted mid-phase SHALL drop Z to 0 without waiting for phase completion.
- This is the only permitted truncated pulse.
REQ-022 After RN rises, the first functional edge SHALL behave as IDLE per REQ-007 and REQ-015.

Verification
REQ-023 Default run: release reset, hold EN=1, no LOAD.
- Z=1 at edge 1, then toggles every cycle (period 2).
- RUN=1 from edge 1.
REQ-024 Idle load: in IDLE, LOAD=1 with DIV=3.
- Next cycle: ACK=1, PEND=0, ACT=3.
- Then EN=1 gives Z high for 4 cycles and low for 4 cycles, repeatedly.
REQ-025 Mid-period load: running at ACT=3, LOAD with DIV=1 during HIGH, then LOAD with DIV=0 during the same LOW.
- The current 8-cycle period completes unchanged.
- A single ACK occurs at the LOW exit.
- The following period is 2 cycles (ACT=0).
REQ-026 Graceful stop: running at ACT=2, drop EN at HIGH cycle 1.
- Z completes 3 high and 3 low cycles, then enters IDLE.
- RUN=0 after the LOW exit edge; Z stays 0.
REQ-027 Coincident load: LOAD with DIV=5 on the LOW-exit edge while PDV=2 is pending.
- ACT=2 applies and ACK pulses.
- PEND stays 1 and PDV=5.
- ACT=5 applies at the next LOW exit.
REQ-028 Async reset: assert RN=0 mid-HIGH at ACT=7.
- Z, RUN, PEND and ACK go 0 without a CLK edge.
- ACT reads back as 0 through divide-by-2 behaviour after release.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctl.sv
// Glitch-free programmable clock divider controller: even ratios 2..32, 50% duty,
// ratio changes deferred to period boundaries, graceful stop on EN deassertion.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_ctl (
  input  logic       CLK,
  input  logic       RN,
  input  logic       EN,
  input  logic [3:0] DIV,
  input  logic       LOAD,
  output logic       Z,
  output logic       RUN,
  output logic       PEND,
  output logic       ACK,
  inout  wire        VDD,
  inout  wire        VSS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] act_reg, act_next;
  logic [3:0] pdv_reg, pdv_next;
  logic       pend_reg, pend_next;
  logic       ack_reg, ack_next;
  logic       z_reg, z_next;
  logic       run_reg, run_next;
  logic       phase_end;
  logic       boundary;
  logic       apply;

  // Power pins carry no logic; fold them into a sink so they are not left dangling.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      act_reg   <= 4'd0;
      pdv_reg   <= 4'd0;
      pend_reg  <= 1'b0;
      ack_reg   <= 1'b0;
      z_reg     <= 1'b0;
      run_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      act_reg   <= act_next;
      pdv_reg   <= pdv_next;
      pend_reg  <= pend_next;
      ack_reg   <= ack_next;
      z_reg     <= z_next;
      run_reg   <= run_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    phase_end  = (cnt_reg == act_reg);
    case (state_reg)
      IDLE: begin
        cnt_next = 4'd0;
        if (EN) state_next = HIGH;
      end
      HIGH: begin
        if (phase_end) begin
          state_next = LOW;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      LOW: begin
        if (phase_end) begin
          state_next = EN ? HIGH : IDLE;
          cnt_next   = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    // ACT may only move where no period is in flight: idle, or the edge closing LOW.
    boundary  = (state_reg == IDLE) || ((state_reg == LOW) && phase_end);
    apply     = boundary && pend_reg;
    act_next  = apply ? pdv_reg : act_reg;
    pdv_next  = LOAD ? DIV : pdv_reg;
    pend_next = LOAD || (pend_reg && !apply);
    ack_next  = apply;
  end

  // Z and RUN are decoded from the next state so they leave a flop aligned with it.
  always_comb begin
    z_next   = (state_next == HIGH);
    run_next = (state_next != IDLE);
  end

  assign Z    = z_reg;
  assign RUN  = run_reg;
  assign PEND = pend_reg;
  assign ACK  = ack_reg;

endmodule
